// File: rtl/code_entry_pkg.sv
// Shared types and constants for the keypad code-entry controller.
// State encodings are plain 3-bit constants so they read the same in netlists.
package code_entry_pkg;

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_LOCKOUT = 3'd3;
  localparam logic [2:0] ST_PROGRAM = 3'd4;

  typedef enum logic [2:0] {
    ENTRY   = ST_ENTRY,
    OPEN    = ST_OPEN,
    FAIL    = ST_FAIL,
    LOCKOUT = ST_LOCKOUT,
    PROGRAM = ST_PROGRAM
  } state_e;

  localparam logic [3:0] KEY_PROG = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  localparam logic [1:0] MODE_PROMPT = 2'b00;
  localparam logic [1:0] MODE_FAIL   = 2'b01;
  localparam logic [1:0] MODE_PASS   = 2'b10;
  localparam logic [1:0] MODE_BLANK  = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [1:0] mode_of(input logic [2:0] st);
    logic [1:0] m;
    case (st)
      ST_OPEN:    m = MODE_PASS;
      ST_FAIL:    m = MODE_FAIL;
      ST_LOCKOUT: m = MODE_BLANK;
      default:    m = MODE_PROMPT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/code_entry_ctrl_digit_shift_reg.sv
// Four-nibble entry buffer: newest digit in bits [3:0], with a per-nibble valid mask.
// Once all four nibbles are valid further digits are dropped rather than wrapping.
module digit_shift_reg
  import code_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift,
  input  logic        clr,
  input  logic [3:0]  din,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        full
);

  assign full = &valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      valid  <= '0;
    end else if (clr) begin
      digits <= '0;
      valid  <= '0;
    end else if (shift && !full) begin
      digits <= {digits[11:0], din};
      valid  <= {valid[2:0], 1'b1};
    end
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad code-entry controller: collects hex digits, checks them against a
// programmable code, and sequences open / fail / lockout for the display driver.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ENTRY   | collecting digits, prompt shown
//   OPEN    | code accepted, unlock held high until the timer expires
//   FAIL    | wrong or partial code shown, keys ignored until expiry
//   LOCKOUT | too many consecutive failures, display blank, keys ignored
//   PROGRAM | collecting a new code, entered from OPEN with the program key
module code_entry_ctrl
  import code_entry_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int          OPEN_CYCLES  = 50_000_000,
  parameter int          FAIL_CYCLES  = 25_000_000,
  parameter int          LOCK_CYCLES  = 250_000_000,
  parameter int          MAX_TRIES    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] Digits,
  output logic [1:0]  DispMode,
  output logic [3:0]  Valid,
  output logic        unlock,
  output logic        locked_out
);

  localparam int MAX_CYC = max3(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES);
  localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] FAIL_LD = TW'(FAIL_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    MAX_T   = 4'(MAX_TRIES);

  logic [2:0]    state, state_nx;
  logic [3:0]    tries, tries_nx;
  logic [15:0]   code_reg, code_nx;
  logic [TW-1:0] timer, timer_ld;
  logic          timer_zero;
  logic          sh_shift, sh_clr, dig_full;

  assign timer_zero = (timer == '0);

  digit_shift_reg u_digits (
    .clk    (clk),
    .rst_n  (rst_n),
    .shift  (sh_shift),
    .clr    (sh_clr),
    .din    (key_code),
    .digits (Digits),
    .valid  (Valid),
    .full   (dig_full)
  );

  always_comb begin
    state_nx = state;
    tries_nx = tries;
    code_nx  = code_reg;
    sh_shift = 1'b0;
    sh_clr   = 1'b0;
    case (state)
      ST_ENTRY, ST_PROGRAM: begin
        if (key_valid) begin
          if (key_code <= 4'h9) begin
            sh_shift = 1'b1;
          end else if (key_code == KEY_CLR) begin
            sh_clr = 1'b1;
          end else if (key_code == KEY_ENT) begin
            sh_clr = 1'b1;
            if (state == ST_PROGRAM) begin
              // A partial new code is abandoned; the old code stays in force.
              state_nx = ST_ENTRY;
              if (dig_full) code_nx = Digits;
            end else if (dig_full && (Digits == code_reg)) begin
              state_nx = ST_OPEN;
              tries_nx = '0;
            end else begin
              state_nx = ST_FAIL;
              if (tries != 4'hF) tries_nx = tries + 4'd1;
            end
          end
        end
      end
      ST_OPEN: begin
        if (timer_zero) begin
          state_nx = ST_ENTRY;
        end else if (key_valid && (key_code == KEY_PROG)) begin
          state_nx = ST_PROGRAM;
          sh_clr   = 1'b1;
        end
      end
      ST_FAIL: begin
        if (timer_zero) state_nx = (tries >= MAX_T) ? ST_LOCKOUT : ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (timer_zero) begin
          state_nx = ST_ENTRY;
          tries_nx = '0;
        end
      end
      default: begin
        state_nx = ST_ENTRY;
        sh_clr   = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (state_nx)
      ST_OPEN:    timer_ld = OPEN_LD;
      ST_FAIL:    timer_ld = FAIL_LD;
      ST_LOCKOUT: timer_ld = LOCK_LD;
      default:    timer_ld = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ENTRY;
      tries    <= '0;
      code_reg <= DEFAULT_CODE;
      timer    <= '0;
    end else begin
      state    <= state_nx;
      tries    <= tries_nx;
      code_reg <= code_nx;
      if (state_nx != state) timer <= timer_ld;
      else if (!timer_zero)  timer <= timer - TW'(1);
    end
  end

  // Status outputs follow the next state so they line up with Digits/Valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DispMode   <= MODE_PROMPT;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      DispMode   <= mode_of(state_nx);
      unlock     <= (state_nx == ST_OPEN);
      locked_out <= (state_nx == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: a cycle model queues expected outputs each clock,
// compared on the falling edge, plus directed checks on the key scenarios.
`timescale 1ns/1ps
module tb_code_entry_ctrl;

  localparam int OPEN_N  = 8;
  localparam int FAIL_N  = 4;
  localparam int LOCK_N  = 16;
  localparam int TRIES_N = 3;

  localparam int M_ENTRY = 0, M_OPEN = 1, M_FAIL = 2, M_LOCK = 3, M_PROG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] Digits;
  logic [1:0]  DispMode;
  logic [3:0]  Valid;
  logic        unlock;
  logic        locked_out;

  code_entry_ctrl #(
    .DEFAULT_CODE (16'h1234),
    .OPEN_CYCLES  (OPEN_N),
    .FAIL_CYCLES  (FAIL_N),
    .LOCK_CYCLES  (LOCK_N),
    .MAX_TRIES    (TRIES_N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .Digits     (Digits),
    .DispMode   (DispMode),
    .Valid      (Valid),
    .unlock     (unlock),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic [1:0]  m;
    logic        u;
    logic        l;
  } exp_t;

  exp_t sb[$];

  int          m_st;
  int          m_left;
  int          m_tries;
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [15:0] m_code;

  task automatic model_reset();
    m_st = M_ENTRY; m_left = 0; m_tries = 0;
    m_digits = 16'h0; m_valid = 4'h0; m_code = 16'h1234;
  endtask

  task automatic model_clear();
    m_digits = 16'h0; m_valid = 4'h0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc);
    case (m_st)
      M_ENTRY, M_PROG: begin
        if (kv && kc <= 4'h9) begin
          if (m_valid != 4'hF) begin
            m_digits = {m_digits[11:0], kc};
            m_valid  = {m_valid[2:0], 1'b1};
          end
        end else if (kv && kc == 4'hC) begin
          model_clear();
        end else if (kv && kc == 4'hE) begin
          if (m_st == M_PROG) begin
            if (m_valid == 4'hF) m_code = m_digits;
            m_st = M_ENTRY;
          end else if (m_valid == 4'hF && m_digits == m_code) begin
            m_st = M_OPEN; m_left = OPEN_N; m_tries = 0;
          end else begin
            m_st = M_FAIL; m_left = FAIL_N;
            if (m_tries < 15) m_tries++;
          end
          model_clear();
        end
      end
      M_OPEN: begin
        if (m_left == 1) m_st = M_ENTRY;
        else if (kv && kc == 4'hA) begin m_st = M_PROG; model_clear(); end
        else m_left--;
      end
      M_FAIL: begin
        if (m_left == 1) begin
          if (m_tries >= TRIES_N) begin m_st = M_LOCK; m_left = LOCK_N; end
          else m_st = M_ENTRY;
        end else m_left--;
      end
      default: begin
        if (m_left == 1) begin m_st = M_ENTRY; m_tries = 0; end
        else m_left--;
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.d = m_digits;
    e.v = m_valid;
    e.u = (m_st == M_OPEN);
    e.l = (m_st == M_LOCK);
    case (m_st)
      M_OPEN:  e.m = 2'b10;
      M_FAIL:  e.m = 2'b01;
      M_LOCK:  e.m = 2'b11;
      default: e.m = 2'b00;
    endcase
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      sb.delete();
    end else begin
      model_step(key_valid, key_code);
      sb.push_back(model_out());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_digits", 32'(Digits), 32'(e.d));
      chk("sb_valid", 32'(Valid), 32'(e.v));
      chk("sb_mode", 32'(DispMode), 32'(e.m));
      chk("sb_unlock", 32'(unlock), 32'(e.u));
      chk("sb_locked", 32'(locked_out), 32'(e.l));
    end
  end

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'hE);
  endtask

  // Counts cycles while DispMode stays at m, optionally pressing a key every cycle.
  task automatic run_while_mode(input logic [1:0] m, input logic kv, input logic [3:0] kc,
                                output int n);
    n = 0;
    while (DispMode == m && n < 200) begin
      key_valid = kv;
      key_code  = kc;
      @(posedge clk); #1;
      n++;
    end
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] exp_d [4];
    logic [3:0]  exp_v [4];
    logic [15:0] wrong [3];
    exp_d[0] = 16'h0001; exp_d[1] = 16'h0012; exp_d[2] = 16'h0123; exp_d[3] = 16'h1234;
    exp_v[0] = 4'h1; exp_v[1] = 4'h3; exp_v[2] = 4'h7; exp_v[3] = 4'hF;
    wrong[0] = 16'h0000; wrong[1] = 16'h4321; wrong[2] = 16'h1235;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(Digits), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_mode", 32'(DispMode), 32'h0);
    chk("rst_unlock", 32'(unlock), 32'h0);
    chk("rst_locked", 32'(locked_out), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct code opens for exactly OPEN_N cycles
    for (int i = 0; i < 4; i++) begin
      press(exp_d[3][(3-i)*4 +: 4]);
      chk("t1_digits", 32'(Digits), 32'(exp_d[i]));
      chk("t1_valid", 32'(Valid), 32'(exp_v[i]));
    end
    press(4'hE);
    chk("t1_mode_open", 32'(DispMode), 32'h2);
    chk("t1_unlock", 32'(unlock), 32'h1);
    run_while_mode(2'b10, 1'b0, 4'h0, n);
    chk("t1_open_len", 32'(n), 32'(OPEN_N));
    chk("t1_mode_after", 32'(DispMode), 32'h0);
    chk("t1_valid_after", 32'(Valid), 32'h0);

    // Three wrong entries lead to lockout; keys ignored throughout
    for (int t = 0; t < 3; t++) begin
      enter_code(wrong[t]);
      chk("t3_mode_fail", 32'(DispMode), 32'h1);
      run_while_mode(2'b01, 1'b1, 4'h1, n);
      chk("t3_fail_len", 32'(n), 32'(FAIL_N));
    end
    chk("t3_locked", 32'(locked_out), 32'h1);
    chk("t3_mode_blank", 32'(DispMode), 32'h3);
    run_while_mode(2'b11, 1'b1, 4'h5, n);
    chk("t3_lock_len", 32'(n), 32'(LOCK_N));
    chk("t3_locked_after", 32'(locked_out), 32'h0);
    chk("t3_valid_after", 32'(Valid), 32'h0);
    enter_code(16'h1234);
    chk("t3_open_after_lock", 32'(DispMode), 32'h2);
    run_while_mode(2'b10, 1'b0, 4'h0, n);

    // Wrong code, keys pressed during FAIL (including on the expiry cycle)
    enter_code(16'h1235);
    chk("t2_mode_fail", 32'(DispMode), 32'h1);
    run_while_mode(2'b01, 1'b1, 4'h7, n);
    chk("t2_fail_len", 32'(n), 32'(FAIL_N));
    chk("t2_digits", 32'(Digits), 32'h0);
    chk("t2_mode_after", 32'(DispMode), 32'h0);

    // Fifth digit dropped, clear, then partial enter fails
    for (int i = 1; i <= 5; i++) press(4'(i));
    chk("t4_digits_full", 32'(Digits), 32'h1234);
    chk("t4_valid_full", 32'(Valid), 32'hF);
    press(4'hC);
    chk("t4_clr_digits", 32'(Digits), 32'h0);
    chk("t4_clr_valid", 32'(Valid), 32'h0);
    chk("t4_clr_mode", 32'(DispMode), 32'h0);
    press(4'hE);
    chk("t4_partial_fail", 32'(DispMode), 32'h1);
    run_while_mode(2'b01, 1'b0, 4'h0, n);

    // Program a new code from OPEN
    enter_code(16'h1234);
    chk("t5_open", 32'(DispMode), 32'h2);
    press(4'hA);
    chk("t5_prog_mode", 32'(DispMode), 32'h0);
    chk("t5_prog_unlock", 32'(unlock), 32'h0);
    enter_code(16'h9876);
    chk("t5_prog_done", 32'(DispMode), 32'h0);
    chk("t5_prog_valid", 32'(Valid), 32'h0);
    enter_code(16'h1234);
    chk("t5_old_code_fails", 32'(DispMode), 32'h1);
    run_while_mode(2'b01, 1'b0, 4'h0, n);
    enter_code(16'h9876);
    chk("t5_new_code_opens", 32'(DispMode), 32'h2);
    run_while_mode(2'b10, 1'b0, 4'h0, n);
    chk("t5_open_len", 32'(n), 32'(OPEN_N));

    // Reset in the middle of PROGRAM reverts to the default code
    enter_code(16'h9876);
    press(4'hA);
    press(4'h9);
    press(4'h8);
    chk("t6_pre_rst_digits", 32'(Digits), 32'h0098);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_digits", 32'(Digits), 32'h0);
    chk("t6_rst_valid", 32'(Valid), 32'h0);
    chk("t6_rst_mode", 32'(DispMode), 32'h0);
    chk("t6_rst_unlock", 32'(unlock), 32'h0);
    chk("t6_rst_locked", 32'(locked_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    enter_code(16'h1234);
    chk("t6_default_opens", 32'(DispMode), 32'h2);
    chk("t6_unlock", 32'(unlock), 32'h1);
    run_while_mode(2'b10, 1'b0, 4'h0, n);
    chk("t6_open_len", 32'(n), 32'(OPEN_N));
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
Name: code_entry_ctrl

Overview:
- Keypad code-entry controller that sits directly upstream of the seven-segment display driver.
- Accepts decoded key events, accumulates up to four hex digits, and checks them against a stored 16-bit code.
- Sequences pass, fail and lockout states, and programs a new code while unlocked.
- Drives the display's digits, mode and per-digit valid inputs, plus a door-unlock strobe.

Parameters:
- DEFAULT_CODE, 16'h1234, stored code after reset.
- OPEN_CYCLES, 50_000_000, cycles the OPEN state holds unlock high.
- FAIL_CYCLES, 25_000_000, cycles the FAIL state is displayed.
- LOCK_CYCLES, 250_000_000, cycles LOCKOUT ignores keys.
- MAX_TRIES, 3, consecutive failures that trigger LOCKOUT (range 1..15).

Ports:
- clk, in, 1, system clock (same clock as the display driver).
- rst_n, in, 1, asynchronous active-low reset.
- key_valid, in, 1, one-cycle pulse: key_code is valid this cycle.
- key_code, in, 4, 0x0-0x9 digit; 0xA program; 0xC clear; 0xE enter; others ignored.
- Digits, out, 16, entered digits; Digits[3:0] is newest, Digits[15:12] is oldest.
- DispMode, out, 2, 00 entry prompt; 01 fail; 10 pass/open; 11 blank.
- Valid, out, 4, bit i=1 means nibble i holds an entered digit.
- unlock, out, 1, high for the whole of OPEN.
- locked_out, out, 1, high for the whole of LOCKOUT.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs are registered. On reset:
  - Digits=0, Valid=0, DispMode=00, unlock=0, locked_out=0.
  - State=ENTRY, code_reg=DEFAULT_CODE, tries=0, timer=0.
  - A reset mid-operation aborts everything, including PROGRAM; code_reg reverts to DEFAULT_CODE.
- States: ENTRY, OPEN, FAIL, LOCKOUT, PROGRAM. Outputs update the cycle after the key_valid edge (1-cycle latency).
- Digit key (ENTRY or PROGRAM):
  - If Valid != 4'hF: Digits <= {Digits[11:0], key_code}; Valid <= {Valid[2:0], 1'b1}.
  - If Valid == 4'hF: key ignored, no wrap-around.
- Clear (0xC) in ENTRY or PROGRAM: Digits=0, Valid=0. The state is unchanged.
- Enter (0xE) in ENTRY:
  - If Valid==4'hF and Digits==code_reg: go to OPEN, tries=0.
  - Otherwise (including partial entry): go to FAIL, tries=tries+1.
  - Digits and Valid are cleared on either transition.
- OPEN:
  - DispMode=10, unlock=1, timer loads OPEN_CYCLES-1 and counts down. At 0: go to ENTRY, unlock=0.
  - Key 0xA: go to PROGRAM immediately, unlock=0, Digits/Valid cleared.
  - Other keys are ignored.
- FAIL:
  - DispMode=01 for FAIL_CYCLES; keys are ignored.
  - At expiry: if tries>=MAX_TRIES, go to LOCKOUT; else go to ENTRY.
- LOCKOUT:
  - DispMode=11, locked_out=1, Valid=0, all keys ignored for LOCK_CYCLES.
  - At expiry: tries=0, go to ENTRY.
- PROGRAM:
  - DispMode=00, digits accumulate as in ENTRY.
  - Enter with Valid==4'hF: code_reg<=Digits, go to ENTRY, cleared.
  - Enter with a partial entry: go to ENTRY with no code change. tries is unaffected.
  - There is no timeout in PROGRAM.
- ENTRY drives DispMode=00.
- Timer:
  - Single shared down-counter, width $clog2 of the largest CYCLES parameter.
  - Loaded on state entry; the state exits on the cycle the count equals 0.
- tries saturates at 15.
- A key_valid pulse on the same cycle as a timer expiry is ignored.

Decomposition:
- Package code_entry_pkg:
  - state enum (ENTRY, OPEN, FAIL, LOCKOUT, PROGRAM).
  - Key constants KEY_PROG=4'hA, KEY_CLR=4'hC, KEY_ENT=4'hE.
  - DispMode constants MODE_PROMPT=2'b00, MODE_FAIL=2'b01, MODE_PASS=2'b10, MODE_BLANK=2'b11.
- One natural sub-module: digit_shift_reg. It holds Digits/Valid with shift, clear and full logic, and is instantiated once.

Test Plan:
All cases use parameters OPEN=8, FAIL=4, LOCK=16, MAX_TRIES=3.
1. Keys 1,2,3,4,E -> Digits steps 0x0001..0x1234 with Valid 1,3,7,F; next cycle DispMode=10, unlock=1 for exactly 8 cycles, then DispMode=00, Valid=0.
2. Keys 1,2,3,5,E -> DispMode=01 for 4 cycles, then 00; keys pressed during FAIL leave Digits=0.
3. Three wrong entries -> after the third FAIL, locked_out=1 and DispMode=11 for 16 cycles; keys ignored; then ENTRY with tries=0; a correct code now opens.
4. Keys 1,2,3,4,5 -> Digits=0x1234, fifth digit dropped; C -> Digits=0, Valid=0; then E -> FAIL.
5. Open, press A, keys 9,8,7,6,E -> code_reg=0x9876; 1234,E fails and 9876,E opens.
6. rst_n low mid-PROGRAM (after keys 9,8) -> all outputs at reset values immediately; 1234,E opens.
